fc_pack32x4_to144: RTL and testbench



---
 rtl/fc_pack_pkg.sv | 29 ++
 rtl/fc_pack_idle_timer.sv | 41 ++++
 rtl/fc_pack32x4_to144.sv | 132 +++++++++++++
 tb/tb_fc_pack32x4_to144.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pack_pkg.sv
// Shared definitions for the 32-bit to 144-bit FC word packer.
// Entry layout: four 32-bit lanes, then a 16-bit metadata field at bit 128.
// Optional lane parity is controlled by the FC_PACK_LANE_PARITY_EN macro.
package fc_pack_pkg;

    localparam int LANE_W  = 32;
    localparam int LANES   = 4;
    localparam int ENTRY_W = 144;

    localparam int MASK_LSB = 128;
    localparam int SOF_BIT  = 132;
    localparam int EOF_BIT  = 133;
    localparam int PAR_LSB  = 134;

    // Metadata field occupying entry bits [143:128].
    typedef struct packed {
        logic [5:0] rsvd;
        logic [3:0] par;
        logic       eof;
        logic       sof;
        logic [3:0] mask;
    } fc_meta_t;

    // Even-parity bit for one lane: total number of ones including this bit is even.
    function automatic logic lane_parity(input logic [LANE_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fc_pack_idle_timer.sv
// Idle timer for the FC packer.
// Counts cycles while an open partial entry sees no new word and emits a
// one-cycle close pulse on the FLUSH_TIMEOUT-th idle cycle.
// FLUSH_TIMEOUT = 0 removes the timer entirely.
module fc_pack_idle_timer #(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic close_pulse
);

    generate
        if (FLUSH_TIMEOUT == 0) begin : g_off
            assign close_pulse = 1'b0;
        end else begin : g_on
            localparam int CW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(FLUSH_TIMEOUT - 1);

            logic [CW-1:0] idle_cnt_r;
            logic          hit_s;

            assign hit_s       = run & ~clr & (idle_cnt_r == LAST);
            assign close_pulse = hit_s;

            // Idle counter: restarts on any accepted word, when nothing is open, or on close.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idle_cnt_r <= '0;
                end else if (clr | ~run | hit_s) begin
                    idle_cnt_r <= '0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fc_pack32x4_to144.sv
// Packs a valid/ready stream of 32-bit FC words into 144-bit FIFO entries.
// Up to four words per entry plus lane mask, SOF and EOF metadata. Partial
// entries close on EOF, on a new SOF, or after an idle timeout.
// Optional macro FC_PACK_LANE_PARITY_EN adds per-lane even parity in [137:134].
module fc_pack32x4_to144
    import fc_pack_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_eof,
    output logic                 in_ready,
    output logic [143:0]         fifo_data,
    output logic                 fifo_wrreq,
    input  logic                 fifo_full,
    output logic [CNT_WIDTH-1:0] entry_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 busy
);

    logic [ENTRY_W-1:0]   acc_r;
    logic [ENTRY_W-1:0]   acc_n_s;
    logic [1:0]           lidx_r;
    logic [1:0]           lidx_n_s;
    logic                 pend_r;
    logic                 pend_n_s;
    logic [CNT_WIDTH-1:0] entry_cnt_r;
    logic [CNT_WIDTH-1:0] frame_cnt_r;

    logic write_s;
    logic sof_split_s;
    logic accept_s;
    logic run_s;
    logic timeout_s;

    // A pending entry drains whenever the FIFO has room.
    assign write_s     = pend_r & ~fifo_full;
    // A SOF arriving mid-entry first closes the partial entry, then is taken as lane 0.
    assign sof_split_s = in_valid & in_sof & (lidx_r != 2'd0) & ~pend_r;
    assign in_ready    = (~pend_r | ~fifo_full) & ~sof_split_s;
    assign accept_s    = in_valid & in_ready;
    assign run_s       = (lidx_r != 2'd0) & ~pend_r;

    assign fifo_data   = acc_r;
    assign fifo_wrreq  = write_s;
    assign entry_cnt   = entry_cnt_r;
    assign frame_cnt   = frame_cnt_r;
    assign busy        = pend_r | (lidx_r != 2'd0);

    fc_pack_idle_timer #(
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_s),
        .clr        (accept_s),
        .close_pulse(timeout_s)
    );

    // Next accumulator/lane/pending state: drain, then accept or force-close.
    always_comb begin
        acc_n_s  = acc_r;
        lidx_n_s = lidx_r;
        pend_n_s = pend_r;
        if (write_s) begin
            acc_n_s  = '0;
            pend_n_s = 1'b0;
        end else begin
            pend_n_s = pend_r;
        end
        if (accept_s) begin
            // Pending implies lidx==0, so a word accepted during a drain lands in a fresh lane 0.
            for (int k = 0; k < LANES; k++) begin
                acc_n_s[k*LANE_W +: LANE_W] = (lidx_r == 2'(k)) ? in_data : acc_n_s[k*LANE_W +: LANE_W];
                acc_n_s[MASK_LSB + k]       = (lidx_r == 2'(k)) ? 1'b1 : acc_n_s[MASK_LSB + k];
`ifdef FC_PACK_LANE_PARITY_EN
                acc_n_s[PAR_LSB + k]        = (lidx_r == 2'(k)) ? lane_parity(in_data) : acc_n_s[PAR_LSB + k];
`endif
            end
            acc_n_s[SOF_BIT] = (lidx_r == 2'd0) ? in_sof : acc_n_s[SOF_BIT];
            if ((lidx_r == 2'd3) || in_eof) begin
                pend_n_s         = 1'b1;
                lidx_n_s         = 2'd0;
                acc_n_s[EOF_BIT] = in_eof;
            end else begin
                lidx_n_s = lidx_r + 2'd1;
            end
        end else if (sof_split_s | timeout_s) begin
            pend_n_s = 1'b1;
            lidx_n_s = 2'd0;
        end else begin
            lidx_n_s = lidx_r;
        end
    end

    // Packing state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            lidx_r <= 2'd0;
            pend_r <= 1'b0;
        end else begin
            acc_r  <= acc_n_s;
            lidx_r <= lidx_n_s;
            pend_r <= pend_n_s;
        end
    end

    // Entry and frame statistics, counted on each FIFO write; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_cnt_r <= '0;
            frame_cnt_r <= '0;
        end else if (write_s) begin
            entry_cnt_r <= entry_cnt_r + CNT_WIDTH'(1);
            if (acc_r[EOF_BIT]) begin
                frame_cnt_r <= frame_cnt_r + CNT_WIDTH'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end else begin
            entry_cnt_r <= entry_cnt_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

endmodule

// File: tb/tb_fc_pack32x4_to144.sv
// Scoreboard bench for fc_pack32x4_to144: stimulus pushes expected entries,
// a negedge monitor pops and compares on every FIFO write.
module tb_fc_pack32x4_to144;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_sof;
    logic         in_eof;
    logic         in_ready;
    logic [143:0] fifo_data;
    logic         fifo_wrreq;
    logic         fifo_full;
    logic [15:0]  entry_cnt;
    logic [15:0]  frame_cnt;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [143:0] exp_q[$];

    fc_pack32x4_to144 #(.FLUSH_TIMEOUT(16), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_ready  (in_ready),
        .fifo_data (fifo_data),
        .fifo_wrreq(fifo_wrreq),
        .fifo_full (fifo_full),
        .entry_cnt (entry_cnt),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [143:0] mk(input logic [3:0] m, input logic s, input logic e,
                                        input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        logic [143:0] r;
        r = '0;
        r[31:0]    = l0;
        r[63:32]   = l1;
        r[95:64]   = l2;
        r[127:96]  = l3;
        r[131:128] = m;
        r[132]     = s;
        r[133]     = e;
`ifdef FC_PACK_LANE_PARITY_EN
        r[134] = ^l0;
        r[135] = ^l1;
        r[136] = ^l2;
        r[137] = ^l3;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && fifo_wrreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h expected no write", fifo_data);
            end else begin
                logic [143:0] e;
                e = exp_q.pop_front();
                if (fifo_data !== e) begin
                    errors++;
                    $display("FAIL entry: got %h expected %h", fifo_data, e);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic s, input logic e);
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = s;
        in_eof   = e;
    endtask

    task automatic wait_acc();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        drive(d, s, e);
        wait_acc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wrreq"}, {143'd0, fifo_wrreq}, 144'd0);
        chk({tag, "_data"}, fifo_data, 144'd0);
        chk({tag, "_busy"}, {143'd0, busy}, 144'd0);
        chk({tag, "_ready"}, {143'd0, in_ready}, 144'd1);
        chk({tag, "_entry_cnt"}, {128'd0, entry_cnt}, 144'd0);
        chk({tag, "_frame_cnt"}, {128'd0, frame_cnt}, 144'd0);
    endtask

    initial begin
        logic [143:0] e_c;
        rst_n     = 1'b0;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        fifo_full = 1'b0;
        idle(3);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Full 4-word entry with SOF.
        exp_q.push_back(mk(4'b1111, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
        send(32'h11111111, 1'b1, 1'b0);
        send(32'h22222222, 1'b0, 1'b0);
        send(32'h33333333, 1'b0, 1'b0);
        send(32'h44444444, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        @(posedge clk);
        #1;
        chk("t1_entry_cnt", {128'd0, entry_cnt}, 144'd1);
        idle(2);

        // Two words closed by EOF.
        exp_q.push_back(mk(4'b0011, 1'b0, 1'b1, 32'h0000000A, 32'h0000000B, 32'h0, 32'h0));
        send(32'h0000000A, 1'b0, 1'b0);
        send(32'h0000000B, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        @(posedge clk);
        #1;
        chk("t2_frame_cnt", {128'd0, frame_cnt}, 144'd1);
        chk("t2_entry_cnt", {128'd0, entry_cnt}, 144'd2);
        idle(2);

        // Entry closes while FIFO is full; a word is waiting the whole time.
        fifo_full = 1'b1;
        e_c = mk(4'b0011, 1'b1, 1'b1, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'h0, 32'h0);
        exp_q.push_back(e_c);
        exp_q.push_back(mk(4'b0001, 1'b1, 1'b1, 32'hD1D1D1D1, 32'h0, 32'h0, 32'h0));
        send(32'hC1C1C1C1, 1'b1, 1'b0);
        send(32'hC2C2C2C2, 1'b0, 1'b1);
        drive(32'hD1D1D1D1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_full_ready", {143'd0, in_ready}, 144'd0);
            chk("t3_full_wrreq", {143'd0, fifo_wrreq}, 144'd0);
            chk("t3_full_data", fifo_data, e_c);
        end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("t3_drop_ready", {143'd0, in_ready}, 144'd1);
        chk("t3_drop_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        @(negedge clk);
        chk("t3_next_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        @(posedge clk);
        #1;
        chk("t3_entry_cnt", {128'd0, entry_cnt}, 144'd4);
        chk("t3_frame_cnt", {128'd0, frame_cnt}, 144'd3);
        idle(2);

        // Idle timeout: one word, then 16 idle cycles before the write.
        exp_q.push_back(mk(4'b0001, 1'b0, 1'b0, 32'h55555555, 32'h0, 32'h0, 32'h0));
        send(32'h55555555, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t4_no_early_write", {143'd0, fifo_wrreq}, 144'd0);
        end
        @(negedge clk);
        chk("t4_timeout_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        idle(2);

        // SOF split: open 1-word entry, then a SOF word.
        exp_q.push_back(mk(4'b0001, 1'b0, 1'b0, 32'h66666666, 32'h0, 32'h0, 32'h0));
        exp_q.push_back(mk(4'b0001, 1'b1, 1'b1, 32'h77777777, 32'h0, 32'h0, 32'h0));
        send(32'h66666666, 1'b0, 1'b0);
        drive(32'h77777777, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5_split_ready", {143'd0, in_ready}, 144'd0);
        wait_acc();
        @(negedge clk);
        chk("t5_second_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        idle(2);

        // Reset with three words open: nothing written, clean restart.
        send(32'h81818181, 1'b1, 1'b0);
        send(32'h82828282, 1'b0, 1'b0);
        send(32'h83838383, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_busy_before", {143'd0, busy}, 144'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t6_in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back(mk(4'b1111, 1'b1, 1'b0, 32'h91919191, 32'h92929292, 32'h93939393, 32'h94949494));
        send(32'h91919191, 1'b1, 1'b0);
        send(32'h92929292, 1'b0, 1'b0);
        send(32'h93939393, 1'b0, 1'b0);
        send(32'h94949494, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_burst_wrreq", {143'd0, fifo_wrreq}, 144'd1);
        @(posedge clk);
        #1;
        chk("t6_entry_cnt", {128'd0, entry_cnt}, 144'd1);
        idle(4);

        chk("scoreboard_drained", 144'(exp_q.size()), 144'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
